// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
// Address/data widths, data response state encoding and the NOP word.
package imem_pkg;

  localparam int IMEM_AW = 10;
  localparam int IMEM_DW = 32;

  localparam logic [31:0] NOP = 32'h13;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_WAIT = 2'd1,
    D_RESP = 2'd2
  } d_state_e;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating wait counter for the data port.
// hit flags that the data port has waited STARVE_MAX cycles.
module imem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_req,
  input  logic d_ok,
  input  logic f_req,
  input  logic d_gnt,
  output logic hit
);

  localparam logic [2:0] MAX = 3'(STARVE_MAX);

  logic [2:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!d_req || d_gnt) begin
      cnt <= '0;
    end else if (d_ok && f_req && cnt != MAX) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign hit = (cnt == MAX);

endmodule

// File: rtl/imem_port_arbiter.sv
// Fetch/data arbiter for the single-port instruction SRAM.
// IMEM_ARB_PERF_EN adds fetch-stall and data-grant counters.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int AW         = IMEM_AW,
  parameter int DW         = IMEM_DW,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          f_kill,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          d_rready,
  output logic          sram_ceb,
  output logic          sram_web,
  output logic [AW-1:0] sram_a,
  input  logic [DW-1:0] sram_q
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_fstall_cnt,
  output logic [CNT_W-1:0] perf_dgnt_cnt
`endif
);

  d_state_e      state;
  d_state_e      state_nxt;
  logic          own_f;
  logic [DW-1:0] hold;
  logic          d_ok;
  logic          hit;

  assign d_rvalid = (state != D_IDLE);
  assign d_ok     = d_req & (~d_rvalid | d_rready);

  // reset gates the grants so the SRAM is idle the instant it asserts
  assign d_gnt    = ~reset & d_ok & (~f_req | hit);
  assign f_gnt    = ~reset & f_req & ~d_gnt;
  assign sram_ceb = ~(f_gnt | d_gnt);
  assign sram_web = 1'b1;
  assign sram_a   = d_gnt ? d_addr : f_addr;

  assign f_rvalid = own_f & ~f_kill;
  assign f_rdata  = sram_q;
  assign d_rdata  = (state == D_WAIT) ? sram_q : hold;

  imem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .d_req(d_req),
    .d_ok (d_ok),
    .f_req(f_req),
    .d_gnt(d_gnt),
    .hit  (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= D_IDLE;
      own_f <= 1'b0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      own_f <= f_gnt & ~f_kill;
      if (state == D_WAIT) hold <= sram_q;
    end
  end

  // D_WAIT is the landing cycle: data comes straight from sram_q
  always_comb begin
    state_nxt = state;
    unique case (state)
      D_IDLE: begin
        if (d_gnt) state_nxt = D_WAIT;
      end
      D_WAIT, D_RESP: begin
        if (d_rready) state_nxt = d_gnt ? D_WAIT : D_IDLE;
        else          state_nxt = D_RESP;
      end
      default: state_nxt = D_IDLE;
    endcase
  end

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fstall_cnt <= '0;
      perf_dgnt_cnt   <= '0;
    end else begin
      if (f_req && !f_gnt) perf_fstall_cnt <= perf_fstall_cnt + 1'b1;
      if (d_gnt)           perf_dgnt_cnt   <= perf_dgnt_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter with a behavioural SRAM.
// Define IMEM_ARB_PERF_EN to also check the perf counters.
module tb_imem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_kill = 1'b0;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_rready = 1'b0;
  logic          sram_ceb;
  logic          sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_q = '0;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0]   perf_fstall_cnt;
  logic [31:0]   perf_dgnt_cnt;
`endif

  imem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(SM), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_kill(f_kill),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rready(d_rready),
    .sram_ceb(sram_ceb), .sram_web(sram_web),
    .sram_a(sram_a), .sram_q(sram_q)
`ifdef IMEM_ARB_PERF_EN
    , .perf_fstall_cnt(perf_fstall_cnt)
    , .perf_dgnt_cnt(perf_dgnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk)
    if (!sram_ceb && sram_web) sram_q <= mem[sram_a];

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t fq[$];
  exp_t dq[$];

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  w = 0;
  bit  mon_en = 1'b0;
  bit  last_f = 1'b0;
  bit  last_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d", name, cyc);
  endtask

  // one clock of stimulus plus the reference arbitration decision
  task automatic step(input bit fr, input logic [AW-1:0] fa,
                      input bit dr, input logic [AW-1:0] da,
                      input bit rr, input bit kill);
    bit dv, dok, eg_d, eg_f;
    @(posedge clk);
    #1;
    cyc++;
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
    d_rready = rr; f_kill = kill;
    if (kill && fq.size() > 0 && fq[$].due == cyc) void'(fq.pop_back());
    dv   = (dq.size() > 0) && (dq[0].due <= cyc);
    dok  = dr && (!dv || rr);
    eg_d = dok && (!fr || w == SM);
    eg_f = fr && !eg_d;
    #1;
    chk("f_gnt", {31'b0, f_gnt}, {31'b0, eg_f});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
    chk("sram_ceb", {31'b0, sram_ceb}, {31'b0, !(eg_f || eg_d)});
    if (eg_d) chk("sram_a_d", {22'b0, sram_a}, {22'b0, da});
    else if (eg_f) chk("sram_a_f", {22'b0, sram_a}, {22'b0, fa});
    if (eg_f && !kill) fq.push_back('{cyc + 1, mem[fa]});
    if (eg_d) dq.push_back('{cyc + 1, mem[da]});
    if (!dr || eg_d) w = 0;
    else if (dok && fr && w < SM) w++;
    last_f = eg_f;
    last_d = eg_d;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (fq.size() > 0 && fq[0].due < cyc) begin
        flag("f_rvalid_missing");
        void'(fq.pop_front());
      end
      if (f_rvalid) begin
        if (fq.size() > 0 && fq[0].due == cyc) begin
          chk("f_rdata", f_rdata, fq[0].data);
          void'(fq.pop_front());
        end else begin
          flag("f_rvalid_unexpected");
        end
      end else if (fq.size() > 0 && fq[0].due == cyc) begin
        flag("f_rvalid_missing");
        void'(fq.pop_front());
      end
      if (d_rvalid) begin
        if (dq.size() > 0 && dq[0].due <= cyc) begin
          chk("d_rdata", d_rdata, dq[0].data);
          if (d_rready) void'(dq.pop_front());
        end else begin
          flag("d_rvalid_unexpected");
        end
      end else if (dq.size() > 0 && dq[0].due <= cyc) begin
        flag("d_rvalid_missing");
        void'(dq.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_f_gnt"}, {31'b0, f_gnt}, 32'd0);
    chk({tag, "_d_gnt"}, {31'b0, d_gnt}, 32'd0);
    chk({tag, "_f_rvalid"}, {31'b0, f_rvalid}, 32'd0);
    chk({tag, "_d_rvalid"}, {31'b0, d_rvalid}, 32'd0);
    chk({tag, "_sram_ceb"}, {31'b0, sram_ceb}, 32'd1);
    chk({tag, "_sram_web"}, {31'b0, sram_web}, 32'd1);
  endtask

  initial begin
    bit            fr, dr, rr, kl;
    logic [AW-1:0] fa, da;

    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // sustained contention: data wins every fifth cycle
    for (int i = 0; i < 10; i++) step(1, AW'(i), 1, AW'(10'h200 + i), 1, 0);
    step(0, '0, 0, '0, 1, 0);
`ifdef IMEM_ARB_PERF_EN
    chk("perf_dgnt", perf_dgnt_cnt, 32'd2);
    chk("perf_fstall", perf_fstall_cnt, 32'd2);
`endif

    // fetch streaming alone
    for (int i = 0; i < 8; i++) step(1, AW'(4 + i), 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 0);

    // single data read
    step(0, '0, 1, 10'h100, 1, 0);
    step(0, '0, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 0);

    // killed fetch, then a clean one
    step(1, 10'h020, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 1);
    step(1, 10'h021, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 0);

    // data response held under backpressure with d_req still asserted
    step(0, '0, 1, 10'h155, 0, 0);
    step(0, '0, 1, 10'h156, 0, 0);
    step(0, '0, 1, 10'h156, 0, 0);
    step(0, '0, 1, 10'h156, 0, 0);
    step(0, '0, 1, 10'h156, 1, 0);
    step(0, '0, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 0);

    // randomized traffic with hold-until-grant requests
    fr = 0; dr = 0; fa = '0; da = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!fr || last_f) begin
        fr = ($urandom_range(0, 3) != 0);
        fa = AW'($urandom);
      end
      if (!dr || last_d) begin
        dr = ($urandom_range(0, 2) == 0);
        da = AW'($urandom);
      end
      rr = ($urandom_range(0, 2) != 0);
      kl = ($urandom_range(0, 9) == 0);
      step(fr, fa, dr, da, rr, kl);
    end
    step(0, '0, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 0);

    // reset in the middle of a data transfer
    step(0, '0, 1, 10'h0AA, 1, 0);
    #1;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    fq.delete();
    dq.delete();
    w = 0;
    f_req = 0; d_req = 0; f_kill = 0;
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0, '0, 1, 0);
      chk("post_rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    end
    step(1, 10'h033, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
